// File: rtl/muldiv_pkg.sv
// Shared types and ALU control codes for the HI/LO multiply/divide sequencer.
package muldiv_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_BUSY = 2'd1,
        DIV_BUSY = 2'd2,
        DONE     = 2'd3
    } state_e;

    // Must track alu_defines.vh
    localparam logic [5:0] ALU_MULT  = 6'b011000;
    localparam logic [5:0] ALU_MULTU = 6'b011001;
    localparam logic [5:0] ALU_DIV   = 6'b011010;
    localparam logic [5:0] ALU_DIVU  = 6'b011011;

    function automatic logic is_mul(input logic [5:0] ctl);
        return (ctl == ALU_MULT) || (ctl == ALU_MULTU);
    endfunction

    function automatic logic is_div(input logic [5:0] ctl);
        return (ctl == ALU_DIV) || (ctl == ALU_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// Handshake bundle between the muldiv sequencer (master) and the external divider (slave).
interface muldiv_seq_if #(
    parameter int DATA_W = 32
);
    logic                  div_start_o;
    logic                  div_annul_o;
    logic [DATA_W-1:0]     div_opa_o;
    logic [DATA_W-1:0]     div_opb_o;
    logic                  div_ready_i;
    logic [2*DATA_W-1:0]   div_result_i;

    modport master (
        output div_start_o, div_annul_o, div_opa_o, div_opb_o,
        input  div_ready_i, div_result_i
    );

    modport slave (
        input  div_start_o, div_annul_o, div_opa_o, div_opb_o,
        output div_ready_i, div_result_i
    );
endinterface

// File: rtl/muldiv_seq_mul_pipe.sv
// STAGES-deep signed/unsigned DATA_W x DATA_W multiplier; free-running, result STAGES cycles after inputs.
module mul_pipe #(
    parameter int DATA_W = 32,
    parameter int STAGES = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     a_i,
    input  logic [DATA_W-1:0]     b_i,
    input  logic                  is_signed_i,
    output logic [2*DATA_W-1:0]   prod_o
);

    logic                  sa, sb;
    logic [2*DATA_W-1:0]   a_x, b_x, prod;
    logic [STAGES-1:0][2*DATA_W-1:0] pipe;

    // Extending to full width makes the low 2*DATA_W bits of the product exact for both signednesses
    assign sa   = is_signed_i & a_i[DATA_W-1];
    assign sb   = is_signed_i & b_i[DATA_W-1];
    assign a_x  = {{DATA_W{sa}}, a_i};
    assign b_x  = {{DATA_W{sb}}, b_i};
    assign prod = a_x * b_x;

    always_ff @(posedge clk) begin
        if (!rst) begin
            pipe <= '0;
        end else begin
            pipe[0] <= prod;
            for (int i = 1; i < STAGES; i++)
                pipe[i] <= pipe[i-1];
        end
    end

    assign prod_o = pipe[STAGES-1];

endmodule

// File: rtl/muldiv_seq.sv
// EXE-stage sequencer for MULT/MULTU/DIV/DIVU: stall generation, divider handshake, HI/LO strobe.
// Optional MULDIV_DBZ_FAST_EN: divide-by-zero bypasses the divider and completes immediately.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int MUL_CYCLES = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  op_valid_i,
    input  logic [5:0]            alucontrol_i,
    input  logic [DATA_W-1:0]     opa_i,
    input  logic [DATA_W-1:0]     opb_i,
    input  logic                  flush_i,
    input  logic                  except_i,
    input  logic                  mem_stall_i,
    muldiv_seq_if.master          div_if,
    output logic                  stall_o,
    output logic [2*DATA_W-1:0]   hilo_o,
    output logic                  hilo_valid_o,
    output logic                  busy_o
);

    localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q;
    logic [DATA_W-1:0]     opa_q, opb_q;
    logic [2*DATA_W-1:0]   hilo_q, prod;
    logic                  div_first_q;
    logic                  kill, acc_mul, acc_div, dbz_fast;
    logic                  div_start, div_annul;

    assign kill    = flush_i | except_i;
    assign acc_mul = (state_q == IDLE) & op_valid_i & ~kill & is_mul(alucontrol_i);
    assign acc_div = (state_q == IDLE) & op_valid_i & ~kill & is_div(alucontrol_i);

`ifdef MULDIV_DBZ_FAST_EN
    assign dbz_fast = acc_div & (opb_i == '0);
`else
    assign dbz_fast = 1'b0;
`endif

    // Fed straight from the operand bus so the product lands exactly as the counter expires
    mul_pipe #(
        .DATA_W (DATA_W),
        .STAGES (MUL_CYCLES)
    ) u_mul_pipe (
        .clk         (clk),
        .rst         (rst),
        .a_i         (opa_i),
        .b_i         (opb_i),
        .is_signed_i (alucontrol_i == ALU_MULT),
        .prod_o      (prod)
    );

    always_comb begin
        state_d      = state_q;
        stall_o      = 1'b0;
        hilo_valid_o = 1'b0;
        div_start    = 1'b0;
        div_annul    = 1'b0;
        case (state_q)
            IDLE: begin
                if (acc_mul) begin
                    stall_o = 1'b1;
                    state_d = MUL_BUSY;
                end else if (acc_div) begin
                    stall_o = 1'b1;
                    state_d = dbz_fast ? DONE : DIV_BUSY;
                end
            end
            MUL_BUSY: begin
                stall_o = 1'b1;
                if (kill)
                    state_d = IDLE;
                else if (cnt_q == '0)
                    state_d = DONE;
            end
            DIV_BUSY: begin
                stall_o   = 1'b1;
                div_start = div_first_q;
                if (kill) begin
                    div_annul = rst;
                    state_d   = IDLE;
                end else if (div_if.div_ready_i) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (kill) begin
                    state_d = IDLE;
                end else if (mem_stall_i) begin
                    stall_o = 1'b1;
                end else begin
                    hilo_valid_o = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            hilo_q      <= '0;
            div_first_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_first_q <= acc_div & ~dbz_fast;
            if (acc_mul | acc_div) begin
                opa_q <= opa_i;
                opb_q <= opb_i;
            end
            if (acc_mul)
                cnt_q <= CNT_W'(MUL_CYCLES - 1);
            else if ((state_q == MUL_BUSY) && (cnt_q != '0))
                cnt_q <= cnt_q - CNT_W'(1);
            if ((state_q == MUL_BUSY) && !kill && (cnt_q == '0))
                hilo_q <= prod;
            else if ((state_q == DIV_BUSY) && !kill && div_if.div_ready_i)
                hilo_q <= div_if.div_result_i;
            else if (dbz_fast)
                hilo_q <= {opa_i, {DATA_W{1'b1}}};
        end
    end

    assign div_if.div_start_o = div_start;
    assign div_if.div_annul_o = div_annul;
    assign div_if.div_opa_o   = opa_q;
    assign div_if.div_opb_o   = opb_q;
    assign hilo_o             = hilo_q;
    assign busy_o             = (state_q != IDLE);

endmodule
